instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of control_unit. It holds the program counter, issues requests to instruction memory and buffers one returned instruction. It presents that instruction to decode, which slices the opcode into control_unit, through a valid/ready handshake. PC redirects from branch, jump, jump-mem-indirect and program-mem-copy resolution arrive on a single redirect port; wrong-path fetches are discarded.

Parameters:
ADDRESS_WIDTH, 32, width of PC and instruction-memory address
INSTRUCTION_WIDTH, 32, width of an instruction word
RESET_VECTOR, 32'h0000_0000, PC value after reset (low 2 bits must be 00)

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
imem_request  output  1  fetch request, held high until imem_ready
imem_address  output  ADDRESS_WIDTH  fetch address, stable while imem_request is high
imem_ready  input  1  imem_data valid this cycle; completes the request
imem_data  input  INSTRUCTION_WIDTH  returned instruction word
instruction_valid  output  1  buffered instruction available to decode
instruction  output  INSTRUCTION_WIDTH  buffered instruction; [31:26] feeds control_unit op_code
instruction_pc  output  ADDRESS_WIDTH  address of the buffered instruction
pc_plus_four  output  ADDRESS_WIDTH  instruction_pc + 4, for branch/jump target math
decode_ready  input  1  decode accepts the instruction this cycle
redirect_valid  input  1  one-cycle request to change the PC
redirect_target  input  ADDRESS_WIDTH  new PC
alignment_error  output  1  one-cycle pulse: redirect_target[1:0] != 00

Behaviour:
- Reset (async, reset_n low): pc=RESET_VECTOR, fetch_address=RESET_VECTOR, state=FETCH, instruction_valid=0, instruction=0, instruction_pc=0, alignment_error=0. imem_request is 0 while reset_n is low and 1 in the first cycle after release.
- States: FETCH, DELIVER, DISCARD.
- FETCH:
  - imem_request=1, imem_address=fetch_address.
  - On imem_ready with no redirect: instruction<=imem_data; instruction_pc<=fetch_address; pc<=fetch_address+4; instruction_valid<=1; go to DELIVER.
- DELIVER:
  - imem_request=0; outputs are held stable.
  - On decode_ready: instruction_valid<=0; fetch_address<=pc; go to FETCH.
  - Throughput is one instruction per 3 cycles with a 1-cycle memory.
- DISCARD:
  - imem_request=1 with the old fetch_address held, because the memory cannot abandon a request.
  - On imem_ready: drop the data; fetch_address<=pc; go to FETCH.
- Redirect handling: redirect has priority over everything else in every state. pc<=redirect_target with bits [1:0] forced to 00. alignment_error pulses the next cycle if the target bits [1:0] were nonzero.
  - FETCH, imem_ready=0: request is outstanding; go to DISCARD.
  - FETCH, imem_ready=1 same cycle: returned data is dropped; fetch_address<=target; stay in FETCH.
  - DELIVER: instruction_valid<=0; the buffered instruction is discarded even if decode_ready is high the same cycle; fetch_address<=target; go to FETCH.
  - DISCARD: pc is updated again (last redirect wins); stay in DISCARD.
- Arithmetic: pc+4 wraps modulo 2^ADDRESS_WIDTH. No fault on wrap.
- pc_plus_four is combinational from instruction_pc.
- instruction_valid never drops without either a handshake (decode_ready) or a redirect.
- Reset mid-request: all state clears immediately. Any memory response after reset release in FETCH is treated as a response for RESET_VECTOR; the memory is reset by the same reset_n.

Decomposition:
- Shared cpu package holds:
  - fetch state enum (FETCH, DELIVER, DISCARD);
  - INSTRUCTION_BYTES=4;
  - OPCODE_MSB=31, OPCODE_LSB=26;
  - default RESET_VECTOR.
- No sub-module; the state register, PC, fetch address and output buffer are all in one module.

Test Plan:
- Reset release, 1-cycle memory returning 0x8C010004 at address 0, decode_ready=1 -> instruction_valid high with instruction_pc=0, pc_plus_four=4; next fetch at address 4; 3-cycle cadence.
- decode_ready held low 5 cycles in DELIVER -> instruction, instruction_pc and instruction_valid stable; no imem_request; fetch at +4 resumes the cycle after decode_ready rises.
- 4-cycle memory, redirect to 0x40 in cycle 2 of a fetch at 0x8 -> DISCARD; request held at 0x8 until ready; data dropped; next request at 0x40; no instruction_valid for 0x8.
- Redirect to 0x100 in DELIVER with decode_ready=1 the same cycle -> buffered instruction discarded; next imem_address=0x100.
- Redirect target 0x203 -> alignment_error pulses 1 cycle; next fetch at 0x200.
- Redirect to 0xFFFF_FFFC, then fetch -> following fetch at 0x0000_0000 (wrap); reset_n low mid-DISCARD -> all outputs at reset values immediately.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, instruction geometry and
// the default reset vector used by the fetch unit and its neighbours.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DELIVER = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam int INSTRUCTION_BYTES = 4;
  localparam int OPCODE_MSB        = 31;
  localparam int OPCODE_LSB        = 26;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch unit's instruction-memory, decode and redirect signals.
// Handshakes: imem_request holds with a stable imem_address until imem_ready
// completes it; instruction_valid holds with stable instruction/instruction_pc
// until decode_ready is seen high on a clock edge (or a redirect flushes it).
interface instruction_fetch_unit_if #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int INSTRUCTION_WIDTH = 32
);

  logic                         imem_request;
  logic [ADDRESS_WIDTH-1:0]     imem_address;
  logic                         imem_ready;
  logic [INSTRUCTION_WIDTH-1:0] imem_data;

  logic                         instruction_valid;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic [ADDRESS_WIDTH-1:0]     instruction_pc;
  logic [ADDRESS_WIDTH-1:0]     pc_plus_four;
  logic                         decode_ready;

  logic                         redirect_valid;
  logic [ADDRESS_WIDTH-1:0]     redirect_target;
  logic                         alignment_error;

  modport master (
    output imem_request, imem_address,
    input  imem_ready, imem_data,
    output instruction_valid, instruction, instruction_pc, pc_plus_four,
    input  decode_ready,
    input  redirect_valid, redirect_target,
    output alignment_error
  );

  modport slave (
    input  imem_request, imem_address,
    output imem_ready, imem_data,
    input  instruction_valid, instruction, instruction_pc, pc_plus_four,
    output decode_ready,
    output redirect_valid, redirect_target,
    input  alignment_error
  );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues instruction-memory requests, buffers one
// instruction for decode and squashes wrong-path fetches on redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH     = 32,
  parameter int                       INSTRUCTION_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR      = ADDRESS_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  instruction_fetch_unit_if.master bus,
  output fetch_state_t             debug_state
);

  localparam logic [ADDRESS_WIDTH-1:0] STEP = ADDRESS_WIDTH'(INSTRUCTION_BYTES);

  fetch_state_t                 state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]     pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0]     fetch_address_q, fetch_address_d;
  logic [INSTRUCTION_WIDTH-1:0] instruction_q, instruction_d;
  logic [ADDRESS_WIDTH-1:0]     instruction_pc_q, instruction_pc_d;
  logic                         valid_q, valid_d;
  logic                         alignment_error_q, alignment_error_d;
  logic [ADDRESS_WIDTH-1:0]     aligned_target;

  assign aligned_target = {bus.redirect_target[ADDRESS_WIDTH-1:2], 2'b00};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= FETCH;
      pc_q              <= RESET_VECTOR;
      fetch_address_q   <= RESET_VECTOR;
      instruction_q     <= '0;
      instruction_pc_q  <= '0;
      valid_q           <= 1'b0;
      alignment_error_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      fetch_address_q   <= fetch_address_d;
      instruction_q     <= instruction_d;
      instruction_pc_q  <= instruction_pc_d;
      valid_q           <= valid_d;
      alignment_error_q <= alignment_error_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    fetch_address_d   = fetch_address_q;
    instruction_d     = instruction_q;
    instruction_pc_d  = instruction_pc_q;
    valid_d           = valid_q;
    alignment_error_d = 1'b0;

    if (bus.redirect_valid) begin
      pc_d              = aligned_target;
      alignment_error_d = |bus.redirect_target[1:0];
      case (state_q)
        FETCH: begin
          // An outstanding request cannot be abandoned, so its reply is drained in DISCARD.
          if (bus.imem_ready) fetch_address_d = aligned_target;
          else                state_d         = DISCARD;
        end
        DELIVER: begin
          valid_d         = 1'b0;
          fetch_address_d = aligned_target;
          state_d         = FETCH;
        end
        DISCARD: begin
          if (bus.imem_ready) begin
            fetch_address_d = aligned_target;
            state_d         = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.imem_ready) begin
            instruction_d    = bus.imem_data;
            instruction_pc_d = fetch_address_q;
            pc_d             = fetch_address_q + STEP;
            valid_d          = 1'b1;
            state_d          = DELIVER;
          end
        end
        DELIVER: begin
          if (bus.decode_ready) begin
            valid_d         = 1'b0;
            fetch_address_d = pc_q;
            state_d         = FETCH;
          end
        end
        DISCARD: begin
          if (bus.imem_ready) begin
            fetch_address_d = pc_q;
            state_d         = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // Gated by reset_n so no request is visible while the memory is held in reset.
  assign bus.imem_request      = reset_n && (state_q != DELIVER);
  assign bus.imem_address      = fetch_address_q;
  assign bus.instruction_valid = valid_q;
  assign bus.instruction       = instruction_q;
  assign bus.instruction_pc    = instruction_pc_q;
  assign bus.pc_plus_four      = instruction_pc_q + STEP;
  assign bus.alignment_error   = alignment_error_q;
  assign debug_state           = state_q;

endmodule
